booth_r4_multiplier: RTL and testbench

Parametrised sequential radix-4 Booth multiplier. It is the next generation of the team's radix-2 shift/add Booth datapath and controlpath pair, folded into a single block. It retires 2 multiplier bits per cycle and supports signed and unsigned operands selected per operation. It has a start/busy/done handshake and a registered 2N-bit product. It sits beside the ALU datapath as a multi-cycle multiply unit.

---
 rtl/booth_pkg.sv | 25 ++
 rtl/booth_r4_recoder.sv | 68 ++++++
 rtl/booth_r4_multiplier.sv | 174 +++++++++++++++++
 tb/tb_booth_r4_multiplier.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
package booth_pkg;

    // Controller states, 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    // Partial-product selection produced by the radix-4 recoder.
    typedef enum logic [2:0] {
        PP_ZERO = 3'd0,
        PP_POS1 = 3'd1,
        PP_POS2 = 3'd2,
        PP_NEG1 = 3'd3,
        PP_NEG2 = 3'd4
    } pp_sel_t;

    // Width of a down-counter that must hold the value iter.
    function automatic int cw_width(input int iter);
        return $clog2(iter + 32'sd1);
    endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// Radix-4 Booth recoder: maps one overlapping 3-bit multiplier group to
// {neg, two, zero} selects and the sign-extended (N+4)-bit partial product.
module booth_r4_recoder
    import booth_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [2:0]   i_group,
    input  logic [N+1:0] i_m,
    output logic         o_neg,
    output logic         o_two,
    output logic         o_zero,
    output logic [N+3:0] o_pp
);

    pp_sel_t        w_sel;
    logic [N+3:0]   w_m_wide;
    logic [N+3:0]   w_mag;

    // Decode the {Q[1], Q[0], qm1} group into a partial-product selection.
    always_comb begin
        w_sel = PP_ZERO;
        case (i_group)
            3'b000, 3'b111: w_sel = PP_ZERO;
            3'b001, 3'b010: w_sel = PP_POS1;
            3'b011:         w_sel = PP_POS2;
            3'b100:         w_sel = PP_NEG2;
            3'b101, 3'b110: w_sel = PP_NEG1;
            default:        w_sel = PP_ZERO;
        endcase
    end

    // Expand the selection into the individual control flags.
    always_comb begin
        o_neg  = 1'b0;
        o_two  = 1'b0;
        o_zero = 1'b0;
        case (w_sel)
            PP_ZERO: o_zero = 1'b1;
            PP_POS1: o_two  = 1'b0;
            PP_POS2: o_two  = 1'b1;
            PP_NEG1: o_neg  = 1'b1;
            PP_NEG2: begin
                o_neg = 1'b1;
                o_two = 1'b1;
            end
            default: o_zero = 1'b1;
        endcase
    end

    // Build the partial product: sign-extend M, optionally double, optionally negate.
    always_comb begin
        w_m_wide = {{2{i_m[N+1]}}, i_m};
        if (o_two) begin
            w_mag = {w_m_wide[N+2:0], 1'b0};
        end else begin
            w_mag = w_m_wide;
        end
        if (o_zero) begin
            o_pp = {(N+4){1'b0}};
        end else if (o_neg) begin
            o_pp = ~w_mag + {{(N+3){1'b0}}, 1'b1};
        end else begin
            o_pp = w_mag;
        end
    end

endmodule

// File: rtl/booth_r4_multiplier.sv
// Sequential radix-4 Booth multiplier, signed or unsigned per operation.
// Operands are widened to N+2 bits so both modes share N/2+1 iterations;
// the low 2N bits of {A, Q} form the product.
module booth_r4_multiplier
    import booth_pkg::*;
#(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           signed_mode,
    input  logic [N-1:0]   data_inM,
    input  logic [N-1:0]   data_inQ,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] ans
);

    localparam int ITER = N / 2 + 1;
    localparam int CW   = cw_width(ITER);
    localparam logic [CW-1:0] CNT_LOAD = CW'(ITER);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t           r_state;
    state_t           w_state_next;
    logic [N+1:0]     r_a;
    logic [N+1:0]     r_q;
    logic [N+1:0]     r_m;
    logic             r_qm1;
    logic [CW-1:0]    r_count;
    logic             r_busy;
    logic             r_done;
    logic [2*N-1:0]   r_ans;

    logic [N+1:0]     w_m_ext;
    logic [N+1:0]     w_q_ext;
    logic [N+3:0]     w_pp;
    logic [N+3:0]     w_a_sum;
    logic [N+1:0]     w_a_next;
    logic [N+1:0]     w_q_next;
    logic             w_qm1_next;
    logic             w_last;
    logic             w_neg;
    logic             w_two;
    logic             w_zero;
    logic             w_unused_flags;

    booth_r4_recoder #(
        .N (N)
    ) u_recoder (
        .i_group (w_group_s()),
        .i_m     (r_m),
        .o_neg   (w_neg),
        .o_two   (w_two),
        .o_zero  (w_zero),
        .o_pp    (w_pp)
    );

    // The recoder flags are kept for debug visibility; the adder only needs the partial product.
    assign w_unused_flags = w_neg ^ w_two ^ w_zero;

    // Current Booth group: two low multiplier bits plus the previously shifted-out bit.
    function automatic logic [2:0] w_group_s();
        return {r_q[1:0], r_qm1};
    endfunction

    // Widen the operands to N+2 bits according to the requested signedness.
    always_comb begin
        if (signed_mode) begin
            w_m_ext = {{2{data_inM[N-1]}}, data_inM};
            w_q_ext = {{2{data_inQ[N-1]}}, data_inQ};
        end else begin
            w_m_ext = {2'b00, data_inM};
            w_q_ext = {2'b00, data_inQ};
        end
    end

    // One iteration: accumulate the partial product, then arithmetic shift {A, Q, qm1} right by 2.
    always_comb begin
        w_a_sum    = {{2{r_a[N+1]}}, r_a} + w_pp;
        w_a_next   = w_a_sum[N+3:2];
        w_q_next   = {w_a_sum[1:0], r_q[N+1:2]};
        w_qm1_next = r_q[1];
        w_last     = (r_count == CNT_ONE);
    end

    // Next-state logic for the IDLE -> CALC -> DONE sequence.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = CALC;
                end else begin
                    w_state_next = IDLE;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = CALC;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand capture, iteration datapath and product register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= {(N+2){1'b0}};
            r_q     <= {(N+2){1'b0}};
            r_m     <= {(N+2){1'b0}};
            r_qm1   <= 1'b0;
            r_count <= {CW{1'b0}};
            r_ans   <= {(2*N){1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_m     <= w_m_ext;
                        r_q     <= w_q_ext;
                        r_a     <= {(N+2){1'b0}};
                        r_qm1   <= 1'b0;
                        r_count <= CNT_LOAD;
                    end
                end
                CALC: begin
                    r_a     <= w_a_next;
                    r_q     <= w_q_next;
                    r_qm1   <= w_qm1_next;
                    r_count <= r_count - CNT_ONE;
                    if (w_last) begin
                        r_ans <= {w_a_next[N-3:0], w_q_next};
                    end
                end
                DONE: begin
                    r_count <= {CW{1'b0}};
                end
                default: begin
                    r_count <= {CW{1'b0}};
                end
            endcase
        end
    end

    // Registered status outputs derived from the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_next != IDLE);
            r_done <= (w_state_next == DONE);
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign ans  = r_ans;

endmodule

// File: tb/tb_booth_r4_multiplier.sv
// Self-checking bench for booth_r4_multiplier: directed table at N=16,
// handshake/reset corner sequences, and random regression at N=8/16/32.
module tb_booth_r4_multiplier;

    logic clk;
    logic rst;

    logic        s8_start, s8_sm, s8_busy, s8_done;
    logic [7:0]  s8_m, s8_q;
    logic [15:0] s8_ans;

    logic        s16_start, s16_sm, s16_busy, s16_done;
    logic [15:0] s16_m, s16_q;
    logic [31:0] s16_ans;

    logic        s32_start, s32_sm, s32_busy, s32_done;
    logic [31:0] s32_m, s32_q;
    logic [63:0] s32_ans;

    int checks;
    int failures;

    booth_r4_multiplier #(.N(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(s8_start), .signed_mode(s8_sm),
        .data_inM(s8_m), .data_inQ(s8_q), .busy(s8_busy), .done(s8_done), .ans(s8_ans)
    );

    booth_r4_multiplier #(.N(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(s16_start), .signed_mode(s16_sm),
        .data_inM(s16_m), .data_inQ(s16_q), .busy(s16_busy), .done(s16_done), .ans(s16_ans)
    );

    booth_r4_multiplier #(.N(32)) u_dut32 (
        .clk(clk), .rst(rst), .start(s32_start), .signed_mode(s32_sm),
        .data_inM(s32_m), .data_inQ(s32_q), .busy(s32_busy), .done(s32_done), .ans(s32_ans)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sm;
        logic [15:0] m;
        logic [15:0] q;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [9];

    function automatic int wid(input int w);
        case (w)
            0:       return 8;
            1:       return 16;
            default: return 32;
        endcase
    endfunction

    // Exact product of the operands as integers, reduced mod 2^(2n).
    function automatic logic [127:0] ref_prod(input int n, input logic sm,
                                              input logic [63:0] m, input logic [63:0] q);
        logic signed [127:0] mx, qx, p, lim;
        lim = 128'sd1 <<< n;
        mx = {64'd0, m} & (lim - 128'sd1);
        qx = {64'd0, q} & (lim - 128'sd1);
        if (sm && m[n-1]) mx = mx - lim;
        if (sm && q[n-1]) qx = qx - lim;
        p = mx * qx;
        return p & ((128'sd1 <<< (2 * n)) - 128'sd1);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int w, input logic st, input logic sm,
                         input logic [63:0] m, input logic [63:0] q);
        case (w)
            0: begin s8_start = st;  s8_sm = sm;  s8_m = m[7:0];   s8_q = q[7:0];   end
            1: begin s16_start = st; s16_sm = sm; s16_m = m[15:0]; s16_q = q[15:0]; end
            default: begin s32_start = st; s32_sm = sm; s32_m = m[31:0]; s32_q = q[31:0]; end
        endcase
    endtask

    function automatic logic get_done(input int w);
        case (w)
            0:       return s8_done;
            1:       return s16_done;
            default: return s32_done;
        endcase
    endfunction

    function automatic logic get_busy(input int w);
        case (w)
            0:       return s8_busy;
            1:       return s16_busy;
            default: return s32_busy;
        endcase
    endfunction

    function automatic logic [127:0] get_ans(input int w);
        case (w)
            0:       return {112'd0, s8_ans};
            1:       return {96'd0, s16_ans};
            default: return {64'd0, s32_ans};
        endcase
    endfunction

    // Issue one operation (called #1 after a rising edge) and wait for done.
    // lat counts rising edges from the one that samples start to the one that raises done.
    task automatic run_op(input int w, input logic sm, input logic [63:0] m, input logic [63:0] q,
                          output logic [127:0] got, output int lat,
                          output logic busy_ok, output logic pulse_ok);
        drive(w, 1'b1, sm, m, q);
        @(posedge clk); #1;
        drive(w, 1'b0, ~sm, ~m, ~q);
        lat = 1;
        busy_ok = 1'b1;
        while (!get_done(w) && lat < 200) begin
            if (!get_busy(w)) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (!get_busy(w)) busy_ok = 1'b0;
        got = get_ans(w);
        @(posedge clk); #1;
        pulse_ok = !get_done(w) && !get_busy(w);
    endtask

    task automatic rand_run(input int w);
        int n, r;
        logic [63:0] mask, m, q;
        logic [127:0] got;
        int lat;
        logic bok, pok;
        n = wid(w);
        mask = (64'd1 << n) - 64'd1;
        for (int mode = 0; mode < 2; mode++) begin
            for (int i = 0; i < 1000; i++) begin
                m = {$urandom, $urandom} & mask;
                q = {$urandom, $urandom} & mask;
                r = $urandom_range(0, 7);
                if (r == 0) m = mask;
                if (r == 1) m = 64'd1 << (n - 1);
                if (r == 2) m = 64'd0;
                r = $urandom_range(0, 7);
                if (r == 0) q = mask;
                if (r == 1) q = 64'd1 << (n - 1);
                if (r == 3) q = (64'd1 << (n - 1)) - 64'd1;
                run_op(w, mode[0], m, q, got, lat, bok, pok);
                check($sformatf("rand%0d_ans m=%0h q=%0h s=%0d", n, m, q, mode), got,
                      ref_prod(n, mode[0], m, q));
                check($sformatf("rand%0d_latency", n), lat, n / 2 + 2);
                check($sformatf("rand%0d_busy", n), bok, 1'b1);
                check($sformatf("rand%0d_done_width", n), pok, 1'b1);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] got;
        int lat, n_done;
        logic bok, pok;

        checks = 0;
        failures = 0;
        vecs[0] = '{1'b1, 16'hFFFD, 16'h0005, 32'hFFFFFFF1};
        vecs[1] = '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        vecs[2] = '{1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001};
        vecs[3] = '{1'b1, 16'h8000, 16'h8000, 32'h40000000};
        vecs[4] = '{1'b1, 16'h8000, 16'h0001, 32'hFFFF8000};
        vecs[5] = '{1'b0, 16'h0064, 16'h00C8, 32'h00004E20};
        vecs[6] = '{1'b0, 16'h8000, 16'h8000, 32'h40000000};
        vecs[7] = '{1'b1, 16'h7FFF, 16'h8000, 32'hC0008000};
        vecs[8] = '{1'b0, 16'h0000, 16'h1234, 32'h00000000};

        for (int w = 0; w < 3; w++) drive(w, 1'b0, 1'b0, 64'd0, 64'd0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", s16_busy, 1'b0);
        check("reset_done", s16_done, 1'b0);
        check("reset_ans", s16_ans, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table at N=16.
        for (int i = 0; i < 9; i++) begin
            run_op(1, vecs[i].sm, {48'd0, vecs[i].m}, {48'd0, vecs[i].q}, got, lat, bok, pok);
            check($sformatf("vec%0d_ans", i), got, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), lat, 10);
            check($sformatf("vec%0d_busy", i), bok, 1'b1);
            check($sformatf("vec%0d_done_width", i), pok, 1'b1);
        end

        // start held through CALC and DONE: ignored there, accepted in the next IDLE.
        drive(1, 1'b1, 1'b0, 64'd7, 64'd9);
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b0, 64'd2, 64'd2);
        n_done = 0;
        for (int k = 0; k < 11; k++) begin
            @(posedge clk); #1;
            if (s16_done) begin
                n_done++;
                check("busy_start_ans63", s16_ans, 32'd63);
            end
            if (k == 9) begin
                check("idle_after_done_busy", s16_busy, 1'b0);
                check("idle_after_done_ans", s16_ans, 32'd63);
            end
            if (k == 10) begin
                check("start_in_idle_accepted", s16_busy, 1'b1);
                drive(1, 1'b0, 1'b0, 64'd0, 64'd0);
            end
        end
        check("single_done_pulse", n_done, 1);
        lat = 0;
        while (!s16_done && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        check("second_op_done", s16_done, 1'b1);
        check("second_op_ans4", s16_ans, 32'd4);
        @(posedge clk); #1;

        // Reset four cycles into CALC aborts the operation.
        drive(1, 1'b1, 1'b0, 64'd100, 64'd200);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 64'd0, 64'd0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_busy", s16_busy, 1'b0);
        check("abort_done", s16_done, 1'b0);
        check("abort_ans", s16_ans, 32'd0);
        n_done = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (s16_done) n_done++;
        end
        rst = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (s16_done) n_done++;
        end
        check("abort_no_done", n_done, 0);
        check("abort_ans_held", s16_ans, 32'd0);
        run_op(1, 1'b0, 64'd100, 64'd200, got, lat, bok, pok);
        check("after_abort_ans", got, 32'd20000);
        check("after_abort_latency", lat, 10);

        // Random regression on all three widths in parallel.
        fork
            rand_run(0);
            rand_run(1);
            rand_run(2);
        join

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
